seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial bit-pattern detector; successor to the fixed 4-bit Mealy detector.
//  Runtime-loadable PAT_LEN-bit pattern, runtime overlap/non-overlap select, valid-qualified input.
//  Gives a Mealy match pulse, a registered match copy and a saturating match counter.
//  Sits on serial-link / framing paths: sync-word hunt, frame-delimiter detection.
// PARAMETERS
//  PAT_LEN  4  pattern length in bits (2..32)
//  CNT_W    8  width of match_cnt
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  en         in   1        1 = RUN, 0 = IDLE (input ignored)
//  cfg_load   in   1        latch pattern_in and ovl_in; clears match history
//  pattern_in in   PAT_LEN  pattern; bit PAT_LEN-1 is the first bit received
//  ovl_in     in   1        1 = overlapping detection, 0 = non-overlapping
//  din_valid  in   1        din qualifier
//  din        in   1        serial data bit
//  clear_cnt  in   1        synchronous clear of match_cnt
//  match      out  1        Mealy: combinational, same cycle as the final pattern bit
//  match_q    out  1        match registered; one cycle after match
//  match_cnt  out  CNT_W    saturating count of matches
//  fill       out  $clog2(PAT_LEN+1)  bits currently held toward a match
// BEHAVIOUR
//  Reset values: state=IDLE, hist=0, fill=0, pattern_q=0, ovl_q=1, match_q=0, match_cnt=0.
//   match is 0 while in reset.
//  FSM states and transitions:
//   - IDLE -> RUN when en=1 and cfg_load=0.
//   - RUN -> IDLE when en=0; hist and fill are held, not cleared.
//  cfg_load (any state):
//   - pattern_q<=pattern_in, ovl_q<=ovl_in, hist<=0, fill<=0.
//   - din is ignored that cycle; match=0.
//   - cfg_load has priority over din_valid.
//  Accepted bit: RUN and din_valid and !cfg_load.
//   - nxt = {hist[PAT_LEN-2:0], din}; hist<=nxt; fill<=min(fill+1, PAT_LEN).
//  match = accepted and (fill >= PAT_LEN-1) and (nxt == pattern_q).
//  On match:
//   - ovl_q=1: fill stays saturated at PAT_LEN, so the next bits can complete an overlapping match.
//   - ovl_q=0: fill<=0; no bit of the matched pattern is reused.
//  Cycles with din_valid=0 neither shift nor clear; a pattern may span idle gaps.
//  match_q<=match every cycle; latency 1.
//  match_cnt:
//   - +1 per match; saturates at 2^CNT_W-1 (no wrap).
//   - clear_cnt has priority over a simultaneous match (result 0).
//   - Not cleared by cfg_load.
//  Reset mid-sequence: partial history is discarded; a new pattern needs PAT_LEN fresh bits.
//  Case 'default' (illegal FSM encoding) -> IDLE, outputs deasserted.
// STRUCTURE
//  Package seqdet_pkg: state encoding (ST_IDLE=1'b0, ST_RUN=1'b1), OVL_ON/OVL_OFF constants.
//  Sub-module sat_counter #(W): clr, inc -> q; saturating, clr priority; instantiated for match_cnt.
//  Main module: FSM, history shift register, fill counter, Mealy compare, output register.
// TESTING
//  1. pattern 1011, ovl=1, stream 1011011 -> match on bits 4 and 7; match_q one cycle later; cnt=2.
//  2. pattern 1011, ovl=0, same stream -> match on bit 4 only; cnt=1.
//  3. pattern 1111, stream of 8 ones -> ovl=1: matches on bits 4..8, cnt=5; ovl=0: bits 4 and 8, cnt=2.
//  4. CNT_W=3, pattern 11, ovl=1, 10 ones -> cnt saturates at 7; clear_cnt with a match in the same cycle -> cnt=0.
//  5. pattern 1011: send 101, assert reset, send 1 -> no match; then 1011 -> match on the 4th bit.
//  6. pattern 1011 with din_valid gaps of 2 cycles between bits -> match; cfg_load mid-pattern -> fill=0, no match.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   state_t : FSM encoding (ST_IDLE / ST_RUN)
//   OVL_ON  : overlapping detection, matched bits may start the next match
//   OVL_OFF : non-overlapping detection, history is consumed by a match
package seqdet_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

endpackage

// File: rtl/seq_detect_param_if.sv
// Control / data / status bundle of seq_detect_param.
//   master : drives en, cfg_load, pattern_in, ovl_in, din_valid, din, clear_cnt;
//            observes match, match_q, match_cnt, fill
//   slave  : the detector side (directions mirrored)
interface seq_detect_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  localparam int FW = $clog2(PAT_LEN + 1);

  logic               en;
  logic               cfg_load;
  logic [PAT_LEN-1:0] pattern_in;
  logic               ovl_in;
  logic               din_valid;
  logic               din;
  logic               clear_cnt;
  logic               match;
  logic               match_q;
  logic [CNT_W-1:0]   match_cnt;
  logic [FW-1:0]      fill;

  modport master (
    output en, cfg_load, pattern_in, ovl_in, din_valid, din, clear_cnt,
    input  match, match_q, match_cnt, fill
  );

  modport slave (
    input  en, cfg_load, pattern_in, ovl_in, din_valid, din, clear_cnt,
    output match, match_q, match_cnt, fill
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high, q -> 0
//   clr   : synchronous clear, wins over inc
//   inc   : count up by one, holding at all-ones
//   q     : count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] Q_MAX = '1;

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && (q_reg != Q_MAX)) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with runtime-loadable pattern and overlap mode.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : seq_detect_param_if slave
//     en         1 = RUN, 0 = IDLE
//     cfg_load   load pattern_in / ovl_in, clear history
//     din_valid  qualifies din
//     clear_cnt  synchronous clear of match_cnt
//     match      Mealy pulse, same cycle as the final pattern bit
//     match_q    match delayed by one cycle
//     match_cnt  saturating match count
//     fill       number of history bits held toward a match
module seq_detect_param
  import seqdet_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              reset,
  seq_detect_param_if.slave bus
);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0] FILL_THR = FW'(PAT_LEN - 1);

  state_t             state_reg, state_next;
  logic [PAT_LEN-1:0] hist_reg;
  logic [PAT_LEN-1:0] pattern_reg;
  logic [FW-1:0]      fill_reg;
  logic               ovl_reg;
  logic               match_q_reg;

  logic               accept;
  logic               match_c;
  logic [PAT_LEN-1:0] hist_next;

  // History as it would look once the current bit is shifted in.
  assign hist_next = {hist_reg[PAT_LEN-2:0], bus.din};

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state; a load cycle keeps IDLE from starting.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.en && !bus.cfg_load) state_next = ST_RUN;
      ST_RUN:  if (!bus.en)                 state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs. A match needs PAT_LEN-1 bits already held plus the current one.
  always_comb begin
    accept  = 1'b0;
    match_c = 1'b0;
    case (state_reg)
      ST_RUN: begin
        accept  = bus.din_valid && !bus.cfg_load;
        match_c = accept && (fill_reg >= FILL_THR) && (hist_next == pattern_reg);
      end
      default: begin
        accept  = 1'b0;
        match_c = 1'b0;
      end
    endcase
  end

  // Datapath: history, fill level, configuration, registered match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      pattern_reg <= '0;
      ovl_reg     <= OVL_ON;
      match_q_reg <= 1'b0;
    end else begin
      match_q_reg <= match_c;
      if (bus.cfg_load) begin
        pattern_reg <= bus.pattern_in;
        ovl_reg     <= bus.ovl_in;
        hist_reg    <= '0;
        fill_reg    <= '0;
      end else if (accept) begin
        hist_reg <= hist_next;
        // Non-overlapping mode discards the matched bits by emptying fill;
        // the stale history is harmless because fill gates the compare.
        if (match_c && (ovl_reg == OVL_OFF)) begin
          fill_reg <= '0;
        end else if (fill_reg != FILL_MAX) begin
          fill_reg <= fill_reg + 1'b1;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (bus.clear_cnt),
    .inc  (match_c),
    .q    (bus.match_cnt)
  );

  assign bus.match   = match_c;
  assign bus.match_q = match_q_reg;
  assign bus.fill    = fill_reg;
endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_LEN(4), .CNT_W(8)) a ();
  seq_detect_param_if #(.PAT_LEN(2), .CNT_W(3)) b ();

  seq_detect_param #(.PAT_LEN(4), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(a));
  seq_detect_param #(.PAT_LEN(2), .CNT_W(3)) dut_b (.clk(clk), .reset(reset), .bus(b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_m_q[$];
  int exp_mq_q[$];

  always @(posedge clk) cyc++;

  // Monitor: every match / match_q pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    int t;
    if (a.match) begin
      checks++;
      if (exp_m_q.size() == 0) begin
        failures++;
        $display("FAIL match_unexpected cycle=%0d got=1 required=0", cyc);
      end else begin
        t = exp_m_q.pop_front();
        if (t != cyc) begin
          failures++;
          $display("FAIL match_cycle got_cycle=%0d required_cycle=%0d", cyc, t);
        end else $display("match ok cycle=%0d", cyc);
      end
    end
    if (a.match_q) begin
      checks++;
      if (exp_mq_q.size() == 0) begin
        failures++;
        $display("FAIL match_q_unexpected cycle=%0d got=1 required=0", cyc);
      end else begin
        t = exp_mq_q.pop_front();
        if (t != cyc) begin
          failures++;
          $display("FAIL match_q_cycle got_cycle=%0d required_cycle=%0d", cyc, t);
        end else $display("match_q ok cycle=%0d", cyc);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end else $display("check %s ok value=%0d", name, act);
  endtask

  task automatic step(input logic v, input logic d, input logic cfg, input logic clr, input logic em);
    @(posedge clk); #1;
    a.din_valid = v;
    a.din       = d;
    a.cfg_load  = cfg;
    a.clear_cnt = clr;
    if (em) begin
      exp_m_q.push_back(cyc);
      exp_mq_q.push_back(cyc + 1);
    end
  endtask

  task automatic step_b(input logic v, input logic d, input logic cfg, input logic clr);
    @(posedge clk); #1;
    b.din_valid = v;
    b.din       = d;
    b.cfg_load  = cfg;
    b.clear_cnt = clr;
  endtask

  task automatic config_a(input logic [3:0] pat, input logic ovl);
    a.pattern_in = pat;
    a.ovl_in     = ovl;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // load and clear the counter
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // IDLE -> RUN if not running yet
  endtask

  // Send n bits MSB first; em marks bits expected to complete a match.
  task automatic send_bits(input logic [15:0] bits, input logic [15:0] em, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 1'b0, em[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush(input string name);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({name, "_missing_match"}, exp_m_q.size(), 0);
    chk({name, "_missing_match_q"}, exp_mq_q.size(), 0);
    exp_m_q.delete();
    exp_mq_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a.en = 1'b0; a.cfg_load = 1'b0; a.pattern_in = '0; a.ovl_in = 1'b1;
    a.din_valid = 1'b0; a.din = 1'b0; a.clear_cnt = 1'b0;
    b.en = 1'b0; b.cfg_load = 1'b0; b.pattern_in = '0; b.ovl_in = 1'b1;
    b.din_valid = 1'b0; b.din = 1'b0; b.clear_cnt = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_match", int'(a.match), 0);
    chk("reset_match_q", int'(a.match_q), 0);
    chk("reset_fill", int'(a.fill), 0);
    chk("reset_cnt", int'(a.match_cnt), 0);
    reset = 1'b0;
    a.en = 1'b1;

    // 1: 1011 overlapping
    config_a(4'b1011, 1'b1);
    send_bits(16'b1011011, 16'b0001001, 7, 0);
    chk("t1_cnt", int'(a.match_cnt), 2);
    flush("t1");

    // 2: 1011 non-overlapping
    config_a(4'b1011, 1'b0);
    send_bits(16'b1011011, 16'b0001000, 7, 0);
    chk("t2_cnt", int'(a.match_cnt), 1);
    flush("t2");

    // 3: eight ones, both modes
    config_a(4'b1111, 1'b1);
    send_bits(16'hFF, 16'b00011111, 8, 0);
    chk("t3_ovl_cnt", int'(a.match_cnt), 5);
    flush("t3a");
    config_a(4'b1111, 1'b0);
    send_bits(16'hFF, 16'b00010001, 8, 0);
    chk("t3_novl_cnt", int'(a.match_cnt), 2);
    flush("t3b");

    // 5: reset mid-sequence discards history
    config_a(4'b1011, 1'b1);
    send_bits(16'b101, 16'b000, 3, 0);
    chk("t5_fill_before_reset", int'(a.fill), 3);
    reset = 1'b1;
    #1;
    chk("t5_fill_in_reset", int'(a.fill), 0);
    chk("t5_match_in_reset", int'(a.match), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    config_a(4'b1011, 1'b1);
    send_bits(16'b1, 16'b0, 1, 0);
    send_bits(16'b1011, 16'b0001, 4, 0);
    chk("t5_cnt", int'(a.match_cnt), 1);
    flush("t5");

    // 6: gaps between valid bits, then cfg_load mid-pattern
    config_a(4'b1011, 1'b1);
    send_bits(16'b1011, 16'b0001, 4, 2);
    chk("t6_gap_cnt", int'(a.match_cnt), 1);
    config_a(4'b1011, 1'b1);
    send_bits(16'b101, 16'b000, 3, 0);
    chk("t6_fill_mid", int'(a.fill), 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // load wins over a valid bit
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_fill_after_load", int'(a.fill), 0);
    send_bits(16'b1, 16'b0, 1, 0);
    chk("t6_fill_one", int'(a.fill), 1);
    chk("t6_cnt_after_load", int'(a.match_cnt), 0);
    flush("t6");

    // 4: 3-bit counter saturation and clear priority on the PAT_LEN=2 instance
    b.en = 1'b1;
    b.pattern_in = 2'b11;
    b.ovl_in = 1'b1;
    step_b(1'b0, 1'b0, 1'b1, 1'b1);
    step_b(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step_b(1'b1, 1'b1, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_cnt_after_8", int'(b.match_cnt), 7);
    for (int i = 0; i < 2; i++) step_b(1'b1, 1'b1, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_cnt_saturated", int'(b.match_cnt), 7);
    step_b(1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    chk("t4_match_with_clear", int'(b.match), 1);
    step_b(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_cnt_cleared", int'(b.match_cnt), 0);
    step_b(1'b1, 1'b1, 1'b0, 1'b0);
    step_b(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_cnt_after_clear", int'(b.match_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
